// File: rtl/delta_integrator_pkg.sv
// Shared definitions for the delta-coded sample path: state encoding and
// default sample/delta widths used by both the subtractor and integrator sides.
package delta_integrator_pkg;

  localparam int DEF_OWIDTH = 21;
  localparam int DEF_DWIDTH = 22;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/delta_range_fix.sv
// Folds a DWIDTH+1-bit signed sum into an unsigned OWIDTH sample and flags
// out-of-range sums. Define DELTA_INTEGRATOR_SAT_EN to clamp instead of wrap.
module delta_range_fix
  import delta_integrator_pkg::*;
#(
  parameter int OWIDTH = DEF_OWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic [DWIDTH:0]   i_sum,
  output logic [OWIDTH-1:0] o_data,
  output logic              o_ovf
);

  logic w_neg;
  logic w_high;

  // The sum is signed: MSB set means below zero, any other bit above OWIDTH
  // means the value exceeds the largest unsigned sample.
  assign w_neg  = i_sum[DWIDTH];
  assign w_high = |i_sum[DWIDTH-1:OWIDTH];
  assign o_ovf  = w_neg | w_high;

`ifdef DELTA_INTEGRATOR_SAT_EN
  always_comb begin
    o_data = i_sum[OWIDTH-1:0];
    if (w_neg) begin
      o_data = '0;
    end else if (w_high) begin
      o_data = '1;
    end
  end
`else
  assign o_data = i_sum[OWIDTH-1:0];
`endif

endmodule

// File: rtl/delta_integrator.sv
// Streaming delta decoder: frame base followed by signed deltas, rebuilt into
// absolute samples behind a registered valid/ready stage. Range mode: DELTA_INTEGRATOR_SAT_EN.
module delta_integrator
  import delta_integrator_pkg::*;
#(
  parameter int OWIDTH    = DEF_OWIDTH,
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int FRAME_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_sof,
  output logic              err_nosof,
  output logic              err_short,
  output logic              ovf,
  output state_t            dbg_state
);

  localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  // Valid/ready: a word moves on any cycle where valid && ready are both high;
  // the input side is ready whenever the output register is empty or draining.
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [OWIDTH-1:0]  r_acc;
  logic               r_out_valid;
  logic [OWIDTH-1:0]  r_out_data;
  logic               r_out_sof;
  logic               r_err_nosof;
  logic               r_err_short;
  logic               r_ovf;

  logic               w_in_ready;
  logic               w_accept;
  logic [DWIDTH:0]    w_sum;
  logic [OWIDTH-1:0]  w_fix_data;
  logic               w_fix_ovf;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_sum      = {{(DWIDTH + 1 - OWIDTH){1'b0}}, r_acc} + {in_data[DWIDTH-1], in_data};

  delta_range_fix #(
    .OWIDTH(OWIDTH),
    .DWIDTH(DWIDTH)
  ) u_range_fix (
    .i_sum (w_sum),
    .o_data(w_fix_data),
    .o_ovf (w_fix_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_err_nosof <= 1'b0;
      r_err_short <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_err_nosof <= 1'b0;
      r_err_short <= 1'b0;
      r_ovf       <= 1'b0;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (in_sof) begin
          // A base always (re)starts a frame; inside RUN it also cuts the old one short.
          r_err_short <= (r_state == RUN);
          r_acc       <= in_data[OWIDTH-1:0];
          r_out_data  <= in_data[OWIDTH-1:0];
          r_out_sof   <= 1'b1;
          r_out_valid <= 1'b1;
          r_cnt       <= CNT_W'(1);
          r_state     <= RUN;
        end else if (r_state == IDLE) begin
          r_err_nosof <= 1'b1;
        end else begin
          r_acc       <= w_fix_data;
          r_out_data  <= w_fix_data;
          r_out_sof   <= 1'b0;
          r_out_valid <= 1'b1;
          r_ovf       <= w_fix_ovf;
          if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign err_nosof = r_err_nosof;
  assign err_short = r_err_short;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_delta_integrator.sv
// Directed scoreboard bench for delta_integrator with FRAME_LEN=4; expected
// samples and error pulses are queued by the stimulus and popped by a monitor.
module tb_delta_integrator;
  import delta_integrator_pkg::*;

  localparam int OW = 21;
  localparam int DW = 22;
  localparam int FL = 4;
  localparam int W  = OW + 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_sof;
  logic          err_nosof;
  logic          err_short;
  logic          ovf;
  state_t        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Output items are {ovf, sof, data}; error items are {nosof, short}.
  logic [W-1:0] exp_q[$];
  logic [1:0]   err_q[$];

  delta_integrator #(
    .OWIDTH(OW),
    .DWIDTH(DW),
    .FRAME_LEN(FL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sof  (out_sof),
    .err_nosof(err_nosof),
    .err_short(err_short),
    .ovf      (ovf),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", name, act, req);
    end
  endfunction

  task automatic exp_out(input logic o, input logic s, input int unsigned d);
    exp_q.push_back({o, s, OW'(d)});
  endtask

  task automatic exp_err(input logic nosof, input logic short_f);
    err_q.push_back({nosof, short_f});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sof, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
  endtask

  task automatic wait_accept();
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout got in_ready=0 expected 1 within 50 cycles");
    end
    #1;
  endtask

  task automatic send(input logic sof, input logic [DW-1:0] d);
    drive(sof, d);
    wait_accept();
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [1:0]   ee;
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_out got ovf=%0b sof=%0b data=%0d expected no output", ovf, out_sof, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({ovf, out_sof, out_data} !== e) begin
            n_errors++;
            $display("FAIL out_sample got ovf=%0b sof=%0b data=%0d expected ovf=%0b sof=%0b data=%0d",
                     ovf, out_sof, out_data, e[W-1], e[W-2], e[OW-1:0]);
          end
        end
      end
      if (err_nosof || err_short) begin
        n_checks++;
        if (err_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_err got nosof=%0b short=%0b expected no pulse", err_nosof, err_short);
        end else begin
          ee = err_q.pop_front();
          if ({err_nosof, err_short} !== ee) begin
            n_errors++;
            $display("FAIL err_pulse got nosof=%0b short=%0b expected nosof=%0b short=%0b",
                     err_nosof, err_short, ee[1], ee[0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sof", 64'(out_sof), 64'd0);
    check("rst_errs", 64'({err_nosof, err_short, ovf}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Basic frame, then a stray delta after the frame closed.
    exp_out(0, 1, 1000); send(1, DW'(1000));
    exp_out(0, 0, 1005); send(0, DW'(5));
    exp_out(0, 0, 1002); send(0, DW'(-3));
    exp_out(0, 0, 1012); send(0, DW'(10));
    exp_err(1, 0);       send(0, DW'(1));
    idle(2);
    check("frame_end_state", 64'(dbg_state), 64'(IDLE));

    // Underflow below zero.
    exp_out(0, 1, 5); send(1, DW'(5));
`ifdef DELTA_INTEGRATOR_SAT_EN
    exp_out(1, 0, 0);       send(0, DW'(-10));
    exp_out(0, 0, 0);       send(0, DW'(0));
    exp_out(0, 0, 0);       send(0, DW'(0));
`else
    exp_out(1, 0, 2097147); send(0, DW'(-10));
    exp_out(0, 0, 2097147); send(0, DW'(0));
    exp_out(0, 0, 2097147); send(0, DW'(0));
`endif
    idle(2);

    // Overflow above 2^21-1.
    exp_out(0, 1, 2097150); send(1, DW'(2097150));
`ifdef DELTA_INTEGRATOR_SAT_EN
    exp_out(1, 0, 2097151); send(0, DW'(4));
    exp_out(0, 0, 2097151); send(0, DW'(0));
    exp_out(0, 0, 2097151); send(0, DW'(0));
`else
    exp_out(1, 0, 2);       send(0, DW'(4));
    exp_out(0, 0, 2);       send(0, DW'(0));
    exp_out(0, 0, 2);       send(0, DW'(0));
`endif
    idle(2);

    // Short frame: base arrives early, the count restarts from the new base.
    exp_out(0, 1, 100); send(1, DW'(100));
    exp_out(0, 0, 101); send(0, DW'(1));
    exp_err(0, 1);
    exp_out(0, 1, 50);  send(1, DW'(50));
    exp_out(0, 0, 51);  send(0, DW'(1));
    exp_out(0, 0, 52);  send(0, DW'(1));
    exp_out(0, 0, 53);  send(0, DW'(1));
    exp_err(1, 0);      send(0, DW'(1));
    idle(2);

    // Backpressure: output holds and input stalls.
    out_ready = 1'b0;
    exp_out(0, 1, 7); send(1, DW'(7));
    exp_out(0, 0, 9); drive(0, DW'(2));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data", 64'(out_data), 64'd7);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    exp_out(0, 0, 9); send(0, DW'(0));
    exp_out(0, 0, 9); send(0, DW'(0));
    idle(2);

    // Asynchronous reset with an output pending mid-frame.
    out_ready = 1'b0;
    send(1, DW'(3));
    idle(1);
    check("pend_out_valid", 64'(out_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(1);
    exp_err(1, 0); send(0, DW'(1));
    idle(5);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("err_q_drained", 64'(err_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/delta_integrator.md
# delta_integrator

Streaming delta decoder: rebuilds absolute samples from the signed differences a subtractor stage produces upstream (`x[n] - x[n-1]`). Each frame opens with an absolute base sample. Every following accepted delta is added to a running accumulator, and the result is emitted through a registered valid/ready output stage. It sits on the receive side of the delta-coded sample path and returns unsigned `OWIDTH` samples to downstream datapath blocks.

## Interface
- `OWIDTH`, 21: width of reconstructed unsigned samples.
- `DWIDTH`, 22: width of signed two's-complement input deltas; must be ≥ `OWIDTH`+1.
- `FRAME_LEN`, 16: samples per frame, base included; must be ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: block can accept the input word.
- `in_sof` input 1: input word is a frame base (absolute value), not a delta.
- `in_data` input `DWIDTH`: signed delta, or absolute base when `in_sof`=1.
- `out_valid` output 1: reconstructed sample valid.
- `out_ready` input 1: downstream accepts the sample.
- `out_data` output `OWIDTH`: reconstructed sample.
- `out_sof` output 1: `out_data` is the first sample of a frame.
- `err_nosof` output 1: one-cycle pulse; a delta arrived outside a frame and was dropped.
- `err_short` output 1: one-cycle pulse; a base arrived before the current frame completed.
- `ovf` output 1: one-cycle pulse; an accumulation left the range [0, 2^`OWIDTH`-1].

## Operation
- Handshake: a transfer happens on a cycle where `valid`&&`ready`. `in_ready` = !`out_valid` || `out_ready`, so input and output can transfer in the same cycle.
- Once asserted, `out_valid`, `out_data` and `out_sof` hold until accepted.
- FSM states:
  - IDLE: waiting for a base.
  - RUN: inside a frame.
- Counter `cnt`, ceil(log2(`FRAME_LEN`)) bits.
- Accepted word in IDLE:
  - `in_sof`=1: `acc` ← `in_data`[`OWIDTH`-1:0], emit with `out_sof`=1, `cnt` ← 1, go to RUN.
  - `in_sof`=0: word is dropped, no output, `err_nosof` pulses, stay IDLE.
- Accepted word in RUN:
  - `in_sof`=1: `err_short` pulses, then the word is handled exactly as a base in IDLE (frame restart).
  - `in_sof`=0: compute `acc` + sext(`in_data`) in `DWIDTH`+1 bits, range-handle per Configuration, emit with `out_sof`=0, `cnt` += 1.
  - When `cnt` reaches `FRAME_LEN`-1 and a delta is accepted, go to IDLE and clear `cnt`.
- A negative base (`in_data` MSB set) is truncated to its low `OWIDTH` bits. `ovf` does not fire for bases.
- Error pulses fire only on accepted words.

## Timing
- Latency: a word accepted at edge N gives `out_valid` after edge N; one cycle.
- Throughput: one sample per clock while `out_ready`=1.
- Reset values: `out_valid`=0, `out_data`=0, `out_sof`=0, `err_nosof`=0, `err_short`=0, `ovf`=0, `acc`=0, `cnt`=0, state IDLE.
- `in_ready`=1 while in reset.
- Reset mid-frame: the pending output is discarded and the next frame must start with a base.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `in_ready`=0 and all state is frozen.

## Configuration
- `DELTA_INTEGRATOR_SAT_EN` defined:
  - sums below 0 clamp to 0; sums above 2^`OWIDTH`-1 clamp to 2^`OWIDTH`-1.
  - `ovf` pulses on each clamp.
- Macro undefined:
  - result wraps modulo 2^`OWIDTH`.
  - `ovf` still pulses when the unwrapped sum is out of range.

## Structure
- Shared package:
  - FSM state encoding (IDLE=0, RUN=1).
  - Default `OWIDTH`/`DWIDTH` constants, shared with the subtractor path.
- One sub-module, `delta_range_fix`: combinational wrap/saturate of the `DWIDTH`+1-bit sum to `OWIDTH` plus overflow flag. It is the only place the macro is tested.

## Test plan
Defaults for all scenarios: `OWIDTH`=21, `FRAME_LEN`=4.
- Frame base 1000, deltas +5, -3, +10, `out_ready`=1 → outputs 1000(sof), 1005, 1002, 1012 on consecutive cycles; then delta +1 → dropped, `err_nosof` pulse.
- Base 5, delta -10 → SAT: 0 with `ovf`; no SAT: 2097147 with `ovf`.
- Base 2097150, delta +4 → SAT: 2097151 with `ovf`; no SAT: 2 with `ovf`.
- Base 100, delta +1, then base 50 → outputs 100, 101, 50(sof) plus `err_short` pulse; the frame count restarts.
- `out_ready` held 0 for 3 cycles after base 7 → `out_data`=7 stable, `in_ready`=0; after release, next delta +2 yields 9.
- `rst` asserted asynchronously mid-frame → `out_valid` drops immediately; delta +1 afterwards → `err_nosof`, no output.
